// File: rtl/perceptron_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : perceptron_pkg
//  Purpose  : Shared types and constants for the perceptron training
//             sequencer: FSM state encoding, standard two-input target
//             truth tables, unit learning rate and default epoch limit.
//  Revision : 1.0 - initial release
// ============================================================================
package perceptron_pkg;

   // Sequencer states, explicit 3-bit encoding.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_SWEEP = 3'd4,
      ST_RESP  = 3'd5
   } seq_state_t;

   // Target truth tables, bit order {t11,t10,t01,t00}.
   localparam logic [3:0] c_TGT_AND  = 4'b1000;
   localparam logic [3:0] c_TGT_OR   = 4'b1110;
   localparam logic [3:0] c_TGT_NAND = 4'b0111;
   localparam logic [3:0] c_TGT_NOR  = 4'b0001;
   localparam logic [3:0] c_TGT_XOR  = 4'b0110;

   // 1.0 in Q4.4.
   localparam int ETA_ONE    = 16;
   // Default epoch limit for a training run.
   localparam int MAX_EPOCHS = 16;

endpackage
`default_nettype wire

// File: rtl/perceptron_train_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : perceptron_train_seq_if
//  Purpose  : Command and result handshake bundle of the perceptron
//             training sequencer.
//  Signals  : cmd_valid/cmd_ready + cmd_* fields   (command, into sequencer)
//             res_valid/res_ready + res_* fields   (result, out of sequencer)
//  Modports : master - command issuer / result consumer
//             slave  - the sequencer
//  Revision : 1.0 - initial release
// ============================================================================
interface perceptron_train_seq_if #(
   parameter int W = 8
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [3:0]          cmd_targets;
   logic signed [W-1:0] cmd_w1;
   logic signed [W-1:0] cmd_w2;
   logic signed [W-1:0] cmd_b;
   logic signed [W-1:0] cmd_eta;
   logic [15:0]         cmd_max_epochs;

   logic                res_valid;
   logic                res_ready;
   logic [3:0]          res_pred;
   logic                res_match;
   logic                res_converged;
   logic                res_timeout;

   modport master (
      output cmd_valid, cmd_targets, cmd_w1, cmd_w2, cmd_b, cmd_eta,
             cmd_max_epochs, res_ready,
      input  cmd_ready, res_valid, res_pred, res_match, res_converged,
             res_timeout
   );

   modport slave (
      input  cmd_valid, cmd_targets, cmd_w1, cmd_w2, cmd_b, cmd_eta,
             cmd_max_epochs, res_ready,
      output cmd_ready, res_valid, res_pred, res_match, res_converged,
             res_timeout
   );
endinterface
`default_nettype wire

// File: rtl/perceptron_seq_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : perceptron_seq_watchdog
//  Purpose  : Loadable down-counter guarding the sequencer WAIT state.
//             Loading presets COUNT-1; each enabled cycle decrements it,
//             so expired is high during the COUNT-th enabled cycle.
//             Only instantiated when PERCEPTRON_SEQ_TIMEOUT_EN is defined.
//  Ports    : clk, reset (sync, active-high)
//             load    - preset the counter
//             en      - count one cycle
//             expired - counter has reached zero
//  Revision : 1.0 - initial release
// ============================================================================
module perceptron_seq_watchdog #(
   parameter int COUNT = 2000
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic expired
);
   localparam int c_CW = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [c_CW-1:0] c_PRESET = c_CW'(COUNT - 1);

   logic [c_CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= c_PRESET;
      end else if (en && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/perceptron_train_seq.sv
`default_nettype none
// ============================================================================
//  Module   : perceptron_train_seq
//  Purpose  : Training command sequencer placed in front of binary_perceptron.
//             Accepts one command, loads initial weights, starts training,
//             waits for done, sweeps all four inputs through the predictor
//             and returns a packed result over a valid/ready handshake.
//  Ports    : clk, reset (sync, active-high)
//             sif          - command/result handshake (slave modport)
//             p_*          - perceptron configuration, control, status
//             busy         - high whenever the FSM is not IDLE
//  Macro    : PERCEPTRON_SEQ_TIMEOUT_EN - enables the WAIT watchdog
//             (TIMEOUT_CYCLES); without it WAIT never times out and
//             res_timeout is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module perceptron_train_seq
   import perceptron_pkg::*;
#(
   parameter int W              = 8,
   parameter int TIMEOUT_CYCLES = 2000,
   parameter int PRED_LAT       = 1
) (
   input  logic                clk,
   input  logic                reset,
   perceptron_train_seq_if.slave sif,
   output logic                p_load_init,
   output logic                p_train_start,
   output logic signed [W-1:0] p_w1_init,
   output logic signed [W-1:0] p_w2_init,
   output logic signed [W-1:0] p_b_init,
   output logic signed [W-1:0] p_eta,
   output logic [3:0]          p_targets,
   output logic [15:0]         p_max_epochs,
   output logic                p_x1,
   output logic                p_x2,
   input  logic                p_done,
   input  logic                p_converged,
   input  logic                p_y,
   output logic                busy
);
   localparam int c_HOLD_W = (PRED_LAT > 0) ? $clog2(PRED_LAT + 1) : 1;
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(PRED_LAT);

   seq_state_t r_state, w_next;

   logic signed [W-1:0] r_w1, r_w2, r_b, r_eta;
   logic [3:0]          r_targets;
   logic [15:0]         r_max_ep;
   logic [3:0]          r_pred;
   logic                r_conv;
   logic                r_timeout;
   logic                r_blank;     // first WAIT cycle: ignore stale done
   logic [1:0]          r_idx;       // sweep index, {x1,x2}
   logic [c_HOLD_W-1:0] r_hold;      // cycles spent on the current index

   logic w_sample;
   logic w_done_take;
   logic w_timeout_hit;
   logic w_in_resp;

   assign w_sample    = (r_state == ST_SWEEP) && (r_hold == c_HOLD_LAST);
   assign w_done_take = (r_state == ST_WAIT) && !r_blank && p_done;
   assign w_in_resp   = (r_state == ST_RESP);

`ifdef PERCEPTRON_SEQ_TIMEOUT_EN
   logic w_wd_expired;

   perceptron_seq_watchdog #(
      .COUNT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .load    (r_state == ST_START),
      .en      (r_state == ST_WAIT),
      .expired (w_wd_expired)
   );

   assign w_timeout_hit   = (r_state == ST_WAIT) && w_wd_expired;
   assign sif.res_timeout = w_in_resp && r_timeout;
`else
   // The watchdog limit has no effect without the watchdog.
   logic w_unused_cfg;
   assign w_unused_cfg    = (TIMEOUT_CYCLES > 0);
   assign w_timeout_hit   = 1'b0;
   assign sif.res_timeout = 1'b0;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (sif.cmd_valid) w_next = ST_LOAD;
         ST_LOAD:  w_next = ST_START;
         ST_START: w_next = ST_WAIT;
         // A genuine done wins over a watchdog expiry in the same cycle.
         ST_WAIT: begin
            if (w_done_take) begin
               w_next = ST_SWEEP;
            end else if (w_timeout_hit) begin
               w_next = ST_RESP;
            end
         end
         ST_SWEEP: if (w_sample && (r_idx == 2'd3)) w_next = ST_RESP;
         ST_RESP:  if (sif.res_ready) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         r_w1      <= '0;
         r_w2      <= '0;
         r_b       <= '0;
         r_eta     <= '0;
         r_targets <= '0;
         r_max_ep  <= '0;
         r_pred    <= '0;
         r_conv    <= 1'b0;
         r_timeout <= 1'b0;
         r_blank   <= 1'b0;
         r_idx     <= '0;
         r_hold    <= '0;
      end else begin
         r_blank <= (r_state == ST_START);
         case (r_state)
            ST_IDLE: begin
               if (sif.cmd_valid) begin
                  r_w1      <= sif.cmd_w1;
                  r_w2      <= sif.cmd_w2;
                  r_b       <= sif.cmd_b;
                  r_eta     <= sif.cmd_eta;
                  r_targets <= sif.cmd_targets;
                  r_max_ep  <= sif.cmd_max_epochs;
                  r_pred    <= '0;
                  r_conv    <= 1'b0;
                  r_timeout <= 1'b0;
               end
            end
            ST_WAIT: begin
               r_idx  <= '0;
               r_hold <= '0;
               if (w_done_take) begin
                  r_conv <= p_converged;
               end else if (w_timeout_hit) begin
                  r_timeout <= 1'b1;
               end
            end
            ST_SWEEP: begin
               // Each index is held 1+PRED_LAT cycles; p_y is taken in the
               // last of them, once the predictor output has settled.
               if (w_sample) begin
                  r_pred[r_idx] <= p_y;
                  r_hold        <= '0;
                  r_idx         <= r_idx + 2'd1;
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------ outputs
   assign sif.cmd_ready     = (r_state == ST_IDLE);
   assign busy              = (r_state != ST_IDLE);
   assign p_load_init       = (r_state == ST_LOAD);
   assign p_train_start     = (r_state == ST_START);
   assign p_x1              = (r_state == ST_SWEEP) && r_idx[1];
   assign p_x2              = (r_state == ST_SWEEP) && r_idx[0];

   assign p_w1_init         = r_w1;
   assign p_w2_init         = r_w2;
   assign p_b_init          = r_b;
   assign p_eta             = r_eta;
   assign p_targets         = r_targets;
   assign p_max_epochs      = r_max_ep;

   // Result fields are only presented while valid; a timed-out run never
   // reports a match even though its zero predictions might equal targets.
   assign sif.res_valid     = w_in_resp;
   assign sif.res_pred      = w_in_resp ? r_pred : 4'd0;
   assign sif.res_converged = w_in_resp && r_conv;
   assign sif.res_match     = w_in_resp && !r_timeout && (r_pred == r_targets);

endmodule
`default_nettype wire

// File: tb/tb_perceptron_train_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_perceptron_train_seq
//  Purpose  : Self-checking bench for perceptron_train_seq. A small
//             behavioural perceptron stub answers train_start after a
//             programmable latency (holding done until the next run clears
//             it) and returns a programmable truth table with one cycle of
//             prediction latency. Results are checked by a scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_perceptron_train_seq;
   import perceptron_pkg::*;

   localparam int W = 8;

   typedef struct packed {
      logic [3:0] pred;
      logic       match;
      logic       conv;
      logic       tout;
   } res_t;

   logic clk;
   logic reset;

   perceptron_train_seq_if #(.W(W)) bus ();

   logic                p_load_init, p_train_start, p_x1, p_x2;
   logic signed [W-1:0] p_w1_init, p_w2_init, p_b_init, p_eta;
   logic [3:0]          p_targets;
   logic [15:0]         p_max_epochs;
   logic                p_done, p_converged, p_y, busy;

   perceptron_train_seq #(
      .W              (W),
      .TIMEOUT_CYCLES (2000),
      .PRED_LAT       (1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .sif           (bus),
      .p_load_init   (p_load_init),
      .p_train_start (p_train_start),
      .p_w1_init     (p_w1_init),
      .p_w2_init     (p_w2_init),
      .p_b_init      (p_b_init),
      .p_eta         (p_eta),
      .p_targets     (p_targets),
      .p_max_epochs  (p_max_epochs),
      .p_x1          (p_x1),
      .p_x2          (p_x2),
      .p_done        (p_done),
      .p_converged   (p_converged),
      .p_y           (p_y),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------- perceptron stub
   int         stub_lat   = 0;
   logic [3:0] stub_table = 4'd0;
   logic       stub_conv  = 1'b0;
   logic       stub_stuck = 1'b0;
   logic       s_done, s_conv, s_busy, s_y;
   int         s_cnt;

   always @(posedge clk) begin
      if (reset) begin
         s_done <= 1'b0;
         s_conv <= 1'b0;
         s_busy <= 1'b0;
         s_cnt  <= 0;
      end else if (p_train_start) begin
         s_busy <= 1'b1;
         s_cnt  <= stub_lat;
      end else if (s_busy) begin
         s_done <= 1'b0;   // stale done lingers through the first WAIT cycle
         if (s_cnt == 0) begin
            s_done <= 1'b1;
            s_conv <= stub_conv;
            s_busy <= 1'b0;
         end else begin
            s_cnt <= s_cnt - 1;
         end
      end
      s_y <= stub_table[{p_x1, p_x2}];
   end

   assign p_done      = stub_stuck ? 1'b0 : s_done;
   assign p_converged = s_conv;
   assign p_y         = s_y;

   // -------------------------------------------------- checking helpers
   int   checks = 0;
   int   errors = 0;
   res_t sb_q[$];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: a result is consumed at the edge following a
   // negedge where valid and ready are both high.
   always @(negedge clk) begin
      if (!reset && bus.res_valid && bus.res_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            res_t e;
            e = sb_q.pop_front();
            check("res_pred",      32'(bus.res_pred),      32'(e.pred));
            check("res_match",     32'(bus.res_match),     32'(e.match));
            check("res_converged", 32'(bus.res_converged), 32'(e.conv));
            check("res_timeout",   32'(bus.res_timeout),   32'(e.tout));
         end
      end
   end

   task automatic check_idle_outputs(input string name);
      check({name, "_p_ctrl"}, 32'({p_load_init, p_train_start, p_x1, p_x2}), 32'd0);
      check({name, "_p_cfg"},  32'({p_w1_init, p_w2_init, p_b_init, p_eta}), 32'd0);
      check({name, "_p_tgt"},  32'({p_targets, p_max_epochs}), 32'd0);
      check({name, "_busy"},   32'(busy), 32'd0);
      check({name, "_cmd_rdy"}, 32'(bus.cmd_ready), 32'd1);
      check({name, "_res"},    32'({bus.res_valid, bus.res_pred, bus.res_match,
                                    bus.res_converged, bus.res_timeout}), 32'd0);
   endtask

   // Issues a command and checks the LOAD/START pulse train. Returns in
   // cycle 3 after acceptance (first WAIT cycle), 1 ns past the edge.
   task automatic issue_cmd(input logic [3:0] tgt, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] b,
                            input logic [7:0] eta, input logic [15:0] ep);
      int n = 0;
      while (!bus.cmd_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid      = 1'b1;
      bus.cmd_targets    = tgt;
      bus.cmd_w1         = w1;
      bus.cmd_w2         = w2;
      bus.cmd_b          = b;
      bus.cmd_eta        = eta;
      bus.cmd_max_epochs = ep;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      check("c1_pulses", 32'({p_load_init, p_train_start}), 32'b10);
      check("c1_busy_rdy", 32'({busy, bus.cmd_ready}), 32'b10);
      check("c1_cfg", 32'({p_w1_init, p_w2_init, p_b_init, p_eta}), {w1, w2, b, eta});
      check("c1_tgt_ep", 32'({p_targets, p_max_epochs}), 32'({tgt, ep}));
      @(posedge clk); #1;
      check("c2_pulses", 32'({p_load_init, p_train_start}), 32'b01);
      @(posedge clk); #1;
      check("c3_pulses_x", 32'({p_load_init, p_train_start, p_x1, p_x2}), 32'd0);
   endtask

   // Waits from cycle 3 for res_valid and checks the cycle it appears in.
   task automatic wait_resp(input string name, input int exp_cycle, input int limit);
      int cyc = 3;
      while (!bus.res_valid && cyc < limit) begin
         @(posedge clk); #1; cyc++;
      end
      check(name, 32'(cyc), 32'(exp_cycle));
   endtask

   task automatic after_handshake(input string name);
      @(posedge clk); #1;
      check({name, "_idle"}, 32'({bus.cmd_ready, busy, bus.res_valid}), 32'b100);
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      reset              = 1'b1;
      bus.cmd_valid      = 1'b0;
      bus.cmd_targets    = '0;
      bus.cmd_w1         = '0;
      bus.cmd_w2         = '0;
      bus.cmd_b          = '0;
      bus.cmd_eta        = '0;
      bus.cmd_max_epochs = '0;
      bus.res_ready      = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      // AND: converges, predicts 1000. done seen in cycle 4+L, result 13+L.
      stub_lat = 5; stub_table = 4'b1000; stub_conv = 1'b1;
      sb_q.push_back('{pred: 4'b1000, match: 1'b1, conv: 1'b1, tout: 1'b0});
      issue_cmd(c_TGT_AND, 8'h00, 8'h00, 8'h00, 8'(ETA_ONE), 16'(MAX_EPOCHS));
      wait_resp("and_latency", 18, 200);
      after_handshake("and");

      // XOR: stale done (converged=1) present in the blanked cycle must be
      // ignored; real result is non-converged, predicting 1110.
      stub_lat = 3; stub_table = 4'b1110; stub_conv = 1'b0;
      sb_q.push_back('{pred: 4'b1110, match: 1'b0, conv: 1'b0, tout: 1'b0});
      issue_cmd(c_TGT_XOR, 8'h10, 8'hF8, 8'h04, 8'(ETA_ONE), 16'(MAX_EPOCHS));
      wait_resp("xor_latency", 16, 200);
      after_handshake("xor");

      // Backpressure: NOR run, result held 10 cycles with ready low while a
      // second command is offered and must be ignored.
      stub_lat = 2; stub_table = 4'b0001; stub_conv = 1'b1;
      bus.res_ready = 1'b0;
      sb_q.push_back('{pred: 4'b0001, match: 1'b1, conv: 1'b1, tout: 1'b0});
      issue_cmd(c_TGT_NOR, 8'h01, 8'h02, 8'h03, 8'h08, 16'd7);
      wait_resp("nor_latency", 15, 200);
      bus.cmd_valid   = 1'b1;
      bus.cmd_targets = 4'b1111;
      for (int i = 0; i < 10; i++) begin
         check("bp_res", 32'({bus.res_valid, bus.res_pred, bus.res_match,
                               bus.res_converged, bus.res_timeout}), 32'b1_0001_110);
         check("bp_cmd_rdy_load", 32'({bus.cmd_ready, p_load_init}), 32'd0);
         check("bp_tgt_kept", 32'(p_targets), 32'(c_TGT_NOR));
         @(posedge clk); #1;
      end
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b1;
      after_handshake("bp_release");

      // Reset in the middle of WAIT, then a full OR run.
      stub_lat = 20; stub_table = 4'b0000; stub_conv = 1'b0;
      issue_cmd(c_TGT_AND, 8'h11, 8'h22, 8'h33, 8'h44, 16'd9);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_idle_outputs("mid_reset");
      stub_lat = 4; stub_table = 4'b1110; stub_conv = 1'b1;
      sb_q.push_back('{pred: 4'b1110, match: 1'b1, conv: 1'b1, tout: 1'b0});
      issue_cmd(c_TGT_OR, 8'h00, 8'h00, 8'h00, 8'(ETA_ONE), 16'(MAX_EPOCHS));
      wait_resp("or_latency", 17, 200);
      after_handshake("or");

`ifdef PERCEPTRON_SEQ_TIMEOUT_EN
      // Timeout: done never arrives; result 2000 cycles after WAIT entry.
      stub_stuck = 1'b1; stub_table = 4'b1111; stub_conv = 1'b1;
      sb_q.push_back('{pred: 4'b0000, match: 1'b0, conv: 1'b0, tout: 1'b1});
      issue_cmd(4'b0000, 8'h00, 8'h00, 8'h00, 8'(ETA_ONE), 16'(MAX_EPOCHS));
      wait_resp("timeout_latency", 2003, 2100);
      after_handshake("timeout");
      stub_stuck = 1'b0;
`endif

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, %0d checks, %0d errors",
               checks, errors);
      $fatal(1, "global time limit reached");
   end

endmodule
`default_nettype wire
